dram_bank_responder: RTL and testbench
======================================

Name: dram_bank_responder

Overview:
- Device-side responder for the controller's command interface: accepts cmd_req/cmd with one-hot bank/row/col selects, tracks the open row per bank, and serialises 8-bit data on the DRAM bit lane.
- Returns cmd_ack with an error status.
- Sits opposite dram_ctrl as the DRAM array model/front end; used in system sims and as the device side of the interface.

Parameters:
- NUM_OF_BANKS, 8, banks; width of bank_sel.
- NUM_OF_ROWS, 128, rows per bank; width of row_sel.
- NUM_OF_COLS, 8, columns per row; width of col_sel.
- DATA_WIDTH, 8, bits per column word, serialised MSB first.
- T_RCD, 3, activate-to-ready cycles.
- T_RP, 2, precharge cycles added when activating an already-open bank.
- T_CAS, 2, read latency before the first data bit.
- T_RFC, 8, refresh busy cycles.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cmd_req  in  1  command request; held high until cmd_ack seen.
- cmd  in  2  00 ACTIVATE, 01 READ, 10 WRITE, 11 REFRESH.
- bank_sel  in  NUM_OF_BANKS  one-hot bank.
- row_sel  in  NUM_OF_ROWS  one-hot row (ACTIVATE only).
- col_sel  in  NUM_OF_COLS  one-hot column (READ/WRITE).
- dram_data_in  in  1  serial write bit from controller.
- dram_data_out  out  1  serial read bit.
- dram_data_oe  out  1  high while driving dram_data_out.
- cmd_ack  out  1  one-cycle completion pulse.
- cmd_err  out  1  valid with cmd_ack; 1 = command rejected.
- bank_open  out  NUM_OF_BANKS  per-bank open-row flags.

Behaviour:
- Reset (async, any state): state IDLE; cmd_ack=0, cmd_err=0, dram_data_oe=0, dram_data_out=0, bank_open=0, timers/shift counters=0. Array contents are not reset and are retained across reset.
- States: IDLE, CHECK, PRE, RCD, CAS, RD_SHIFT, WR_SHIFT, RFC, ACK, RELEASE.
- IDLE: cmd_req=1 at edge t0 latches cmd and all selects, then goes to CHECK. Latencies below count from t0.
- CHECK (t0+1): encode the selects to binary via sub-module. Error conditions:
  - any required select not exactly one-hot (zero or multi-hot);
  - READ/WRITE to a closed bank;
  - READ/WRITE to an open bank whose row was never tracked.
  - On error go to ACK with cmd_err=1, so ack is at t0+2. No array or open-row state changes.
  - REFRESH ignores all selects.
- ACTIVATE:
  - Closed bank: RCD for T_RCD cycles; ack at t0+2+T_RCD.
  - Open bank: PRE for T_RP cycles then RCD; ack at t0+2+T_RP+T_RCD.
  - On ack, open_row[bank]=row and bank_open[bank]=1.
- READ: CAS for T_CAS cycles, then RD_SHIFT for DATA_WIDTH cycles.
  - dram_data_oe=1 and dram_data_out = word[DATA_WIDTH-1-k] in cycle t0+2+T_CAS+k.
  - oe drops the next cycle; ack at t0+2+T_CAS+DATA_WIDTH.
  - Column address is {open_row[bank], col}.
- WRITE: WR_SHIFT samples dram_data_in on edges t0+2 .. t0+1+DATA_WIDTH, MSB first.
  - Word written to the array on the last sample edge.
  - ack at t0+2+DATA_WIDTH; a READ issued immediately after returns the new word.
- REFRESH: RFC for T_RFC cycles; bank_open cleared on entering RFC; ack at t0+2+T_RFC.
- ACK: cmd_ack=1 for exactly one cycle, with cmd_err valid. Then RELEASE.
- RELEASE: waits for cmd_req=0, then IDLE. A held cmd_req never re-triggers the same command. Minimum command-to-command spacing is ack + 1 cycle.
- cmd_req dropping mid-command: the command still completes and acks.
- Select changes after t0 are ignored.
- Timers: down-counters of width $clog2(max(T_RP, T_RCD, T_CAS, T_RFC)+1); a zero-valued parameter skips its state.
- Shift counter width: $clog2(DATA_WIDTH).

Decomposition:
- Shared package dram_pkg holds:
  - cmd encodings CMD_ACT=2'b00, CMD_RD=2'b01, CMD_WR=2'b10, CMD_REF=2'b11;
  - the responder state encoding;
  - default timing constants.
- One sub-module: dram_onehot_enc (parameter WIDTH; inputs onehot; outputs binary[$clog2(WIDTH)-1:0] and valid; valid=1 iff exactly one bit set). Instantiated three times, for bank, row and col.

Test Plan:
- Reset, then ACTIVATE with bank_sel=8'h04, row_sel bit 5 → cmd_ack at t0+5, cmd_err=0, bank_open=8'h04.
- With bank 2 row 5 open: WRITE col_sel=8'h08 with serial bits of 8'hA5 (MSB first), then READ of the same column → write ack at t0+10; read drives 1,0,1,0,0,1,0,1 on cycles t0+4..t0+11 with oe=1; ack at t0+12.
- READ to closed bank 3, and ACTIVATE with bank_sel=8'h06 → each acks at t0+2 with cmd_err=1; bank_open unchanged; oe never asserted.
- ACTIVATE bank 2 row 9 while row 5 is open → ack at t0+7. A READ then returns row-9 data, not the row-5 word 8'hA5.
- REFRESH with two banks open → bank_open=0 from t0+2; ack at t0+10. A following READ returns cmd_err=1.
- Assert rst_b low mid-RD_SHIFT → oe and ack drop immediately and bank_open=0. After release, ACT then READ returns the previously written 8'hA5. Holding cmd_req high after an ack produces no second ack.

Source files
------------

// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_pkg
// Description : Command encodings, responder state encoding and default
//               timing/geometry constants shared by the DRAM device model.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_REF = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHECK    = 4'd1,
        ST_PRE      = 4'd2,
        ST_RCD      = 4'd3,
        ST_CAS      = 4'd4,
        ST_RD_SHIFT = 4'd5,
        ST_WR_SHIFT = 4'd6,
        ST_RFC      = 4'd7,
        ST_ACK      = 4'd8,
        ST_RELEASE  = 4'd9
    } state_e;

    localparam int DEF_NUM_OF_BANKS = 8;
    localparam int DEF_NUM_OF_ROWS  = 128;
    localparam int DEF_NUM_OF_COLS  = 8;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_T_RCD        = 3;
    localparam int DEF_T_RP         = 2;
    localparam int DEF_T_CAS        = 2;
    localparam int DEF_T_RFC        = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_onehot_enc.sv
`default_nettype none
// ============================================================================
// Module      : dram_onehot_enc
// Description : One-hot to binary encoder; valid only for exactly one bit set.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_onehot_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         onehot,
    output logic [$clog2(WIDTH)-1:0] binary,
    output logic                     valid
);

    localparam int BW = $clog2(WIDTH);

    // Clearing the lowest set bit leaves zero only for a power of two.
    assign valid = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);

    always_comb begin
        binary = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) binary = binary | BW'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dram_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_bank_responder
// Description : Device-side DRAM responder: open-row tracking per bank, serial
//               MSB-first data lane and acked command completion with status.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_bank_responder
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_CAS        = DEF_T_CAS,
    parameter int T_RFC        = DEF_T_RFC
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    input  logic                    dram_data_in,
    output logic                    dram_data_out,
    output logic                    dram_data_oe,
    output logic                    cmd_ack,
    output logic                    cmd_err,
    output logic [NUM_OF_BANKS-1:0] bank_open
);

    localparam int BANK_W  = $clog2(NUM_OF_BANKS);
    localparam int ROW_W   = $clog2(NUM_OF_ROWS);
    localparam int COL_W   = $clog2(NUM_OF_COLS);
    localparam int ADDR_W  = BANK_W + ROW_W + COL_W;
    localparam int TMR_W   = $clog2(max4(T_RP, T_RCD, T_CAS, T_RFC) + 1);
    localparam int SHIFT_W = $clog2(DATA_WIDTH);

    localparam logic [TMR_W-1:0]   TMR_RP     = TMR_W'(T_RP);
    localparam logic [TMR_W-1:0]   TMR_RCD    = TMR_W'(T_RCD);
    localparam logic [TMR_W-1:0]   TMR_CAS    = TMR_W'(T_CAS);
    localparam logic [TMR_W-1:0]   TMR_RFC    = TMR_W'(T_RFC);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(DATA_WIDTH - 1);

    state_e                                state_q, state_d;
    logic [1:0]                            cmd_q, cmd_d;
    logic [NUM_OF_BANKS-1:0]               bank_oh_q, bank_oh_d;
    logic [NUM_OF_ROWS-1:0]                row_oh_q, row_oh_d;
    logic [NUM_OF_COLS-1:0]                col_oh_q, col_oh_d;
    logic                                  err_q, err_d;
    logic [TMR_W-1:0]                      tmr_q, tmr_d;
    logic [SHIFT_W-1:0]                    shift_cnt_q, shift_cnt_d;
    logic [DATA_WIDTH-1:0]                 shreg_q, shreg_d;
    logic [NUM_OF_BANKS-1:0]               bank_open_q, bank_open_d;
    logic [NUM_OF_BANKS-1:0]               row_tracked_q, row_tracked_d;
    logic [NUM_OF_BANKS-1:0][ROW_W-1:0]    open_row_q, open_row_d;
    logic                                  data_out_q, data_out_d;
    logic                                  data_oe_q, data_oe_d;
    logic                                  cmd_ack_q, cmd_ack_d;
    logic                                  cmd_err_q, cmd_err_d;

    logic [BANK_W-1:0]     bank_bin;
    logic [ROW_W-1:0]      row_bin;
    logic [COL_W-1:0]      col_bin;
    logic                  bank_ok, row_ok, col_ok;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_array [2**ADDR_W];

    dram_onehot_enc #(.WIDTH(NUM_OF_BANKS)) u_bank_enc (
        .onehot (bank_oh_q),
        .binary (bank_bin),
        .valid  (bank_ok)
    );

    dram_onehot_enc #(.WIDTH(NUM_OF_ROWS)) u_row_enc (
        .onehot (row_oh_q),
        .binary (row_bin),
        .valid  (row_ok)
    );

    dram_onehot_enc #(.WIDTH(NUM_OF_COLS)) u_col_enc (
        .onehot (col_oh_q),
        .binary (col_bin),
        .valid  (col_ok)
    );

    // Column accesses always go through the row currently open in the bank.
    assign mem_addr  = {bank_bin, open_row_q[bank_bin], col_bin};
    assign mem_wdata = {shreg_q[DATA_WIDTH-2:0], dram_data_in};

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        bank_oh_d     = bank_oh_q;
        row_oh_d      = row_oh_q;
        col_oh_d      = col_oh_q;
        err_d         = err_q;
        tmr_d         = tmr_q;
        shift_cnt_d   = shift_cnt_q;
        shreg_d       = shreg_q;
        bank_open_d   = bank_open_q;
        row_tracked_d = row_tracked_q;
        open_row_d    = open_row_q;
        data_out_d    = 1'b0;
        data_oe_d     = 1'b0;
        cmd_ack_d     = 1'b0;
        cmd_err_d     = 1'b0;
        mem_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_req) begin
                    cmd_d     = cmd;
                    bank_oh_d = bank_sel;
                    row_oh_d  = row_sel;
                    col_oh_d  = col_sel;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                err_d       = 1'b0;
                tmr_d       = '0;
                shift_cnt_d = '0;
                case (cmd_q)
                    CMD_ACT: begin
                        if (!bank_ok || !row_ok) begin
                            err_d   = 1'b1;
                            state_d = ST_ACK;
                        end else if (bank_open_q[bank_bin] && (T_RP > 0)) begin
                            tmr_d   = TMR_RP;
                            state_d = ST_PRE;
                        end else if (T_RCD > 0) begin
                            tmr_d   = TMR_RCD;
                            state_d = ST_RCD;
                        end else begin
                            state_d = ST_ACK;
                        end
                    end
                    CMD_RD, CMD_WR: begin
                        if (!bank_ok || !col_ok || !bank_open_q[bank_bin] ||
                            !row_tracked_q[bank_bin]) begin
                            err_d   = 1'b1;
                            state_d = ST_ACK;
                        end else if (cmd_q == CMD_WR) begin
                            state_d = ST_WR_SHIFT;
                        end else begin
                            shreg_d = mem_array[mem_addr];
                            if (T_CAS > 0) begin
                                tmr_d   = TMR_CAS;
                                state_d = ST_CAS;
                            end else begin
                                state_d = ST_RD_SHIFT;
                            end
                        end
                    end
                    CMD_REF: begin
                        bank_open_d = '0;
                        if (T_RFC > 0) begin
                            tmr_d   = TMR_RFC;
                            state_d = ST_RFC;
                        end else begin
                            state_d = ST_ACK;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                endcase
            end
            ST_PRE: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (tmr_q == TMR_W'(1)) begin
                    if (T_RCD > 0) begin
                        tmr_d   = TMR_RCD;
                        state_d = ST_RCD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_RCD, ST_RFC: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (tmr_q == TMR_W'(1)) state_d = ST_ACK;
            end
            ST_CAS: begin
                tmr_d = tmr_q - TMR_W'(1);
                if (tmr_q == TMR_W'(1)) state_d = ST_RD_SHIFT;
            end
            ST_RD_SHIFT: begin
                data_oe_d   = 1'b1;
                data_out_d  = shreg_q[DATA_WIDTH-1];
                shreg_d     = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
                if (shift_cnt_q == SHIFT_LAST) state_d = ST_ACK;
            end
            ST_WR_SHIFT: begin
                shreg_d     = mem_wdata;
                shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
                if (shift_cnt_q == SHIFT_LAST) begin
                    mem_we  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                cmd_ack_d = 1'b1;
                cmd_err_d = err_q;
                if ((cmd_q == CMD_ACT) && !err_q) begin
                    bank_open_d[bank_bin]   = 1'b1;
                    row_tracked_d[bank_bin] = 1'b1;
                    open_row_d[bank_bin]    = row_bin;
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Holding cmd_req must not restart the command just acked.
                if (!cmd_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            bank_oh_q     <= '0;
            row_oh_q      <= '0;
            col_oh_q      <= '0;
            err_q         <= 1'b0;
            tmr_q         <= '0;
            shift_cnt_q   <= '0;
            shreg_q       <= '0;
            bank_open_q   <= '0;
            row_tracked_q <= '0;
            open_row_q    <= '0;
            data_out_q    <= 1'b0;
            data_oe_q     <= 1'b0;
            cmd_ack_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            bank_oh_q     <= bank_oh_d;
            row_oh_q      <= row_oh_d;
            col_oh_q      <= col_oh_d;
            err_q         <= err_d;
            tmr_q         <= tmr_d;
            shift_cnt_q   <= shift_cnt_d;
            shreg_q       <= shreg_d;
            bank_open_q   <= bank_open_d;
            row_tracked_q <= row_tracked_d;
            open_row_q    <= open_row_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            cmd_ack_q     <= cmd_ack_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    // Array contents survive reset, like a real device across a controller reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_array[mem_addr] <= mem_wdata;
    end

    assign dram_data_out = data_out_q;
    assign dram_data_oe  = data_oe_q;
    assign cmd_ack       = cmd_ack_q;
    assign cmd_err       = cmd_err_q;
    assign bank_open     = bank_open_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_bank_responder
// Description : Directed scoreboard bench for the DRAM bank responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_bank_responder;
    import dram_pkg::*;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         cmd_req;
    logic [1:0]   cmd;
    logic [7:0]   bank_sel;
    logic [127:0] row_sel;
    logic [7:0]   col_sel;
    logic         dram_data_in;
    logic         dram_data_out;
    logic         dram_data_oe;
    logic         cmd_ack;
    logic         cmd_err;
    logic [7:0]   bank_open;

    int errors = 0;
    int checks = 0;

    int         lat_q[$];
    logic       err_exp_q[$];
    logic       bit_q[$];
    logic [7:0] model_mem[int];
    int         open_row_m[8];

    always #5 clk = ~clk;

    dram_bank_responder u_dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .cmd_req       (cmd_req),
        .cmd           (cmd),
        .bank_sel      (bank_sel),
        .row_sel       (row_sel),
        .col_sel       (col_sel),
        .dram_data_in  (dram_data_in),
        .dram_data_out (dram_data_out),
        .dram_data_oe  (dram_data_oe),
        .cmd_ack       (cmd_ack),
        .cmd_err       (cmd_err),
        .bank_open     (bank_open)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh2idx(input logic [127:0] v);
        for (int i = 0; i < 128; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [127:0] rowhot(input int n);
        logic [127:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Issue one command, hold it until ack, and score latency/status/serial data.
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [7:0] b,
                           input logic [127:0] r, input logic [7:0] cl, input logic [7:0] wd,
                           input int lat, input logic e, input bit hold);
        int         bi, key;
        bit         done, rd_ok;
        logic [7:0] w;
        bi    = oh2idx({120'd0, b});
        key   = bi * 1024 + open_row_m[bi] * 8 + oh2idx({120'd0, cl});
        rd_ok = (c == CMD_RD) && !e;
        @(negedge clk);
        cmd = c; bank_sel = b; row_sel = r; col_sel = cl; cmd_req = 1'b1;
        lat_q.push_back(lat);
        err_exp_q.push_back(e);
        if (rd_ok) begin
            w = model_mem.exists(key) ? model_mem[key] : 8'h00;
            for (int i = 7; i >= 0; i--) bit_q.push_back(w[i]);
        end
        @(posedge clk);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cmd = ~c; bank_sel = ~b; row_sel = ~r; col_sel = ~cl;
            end
            if (c == CMD_WR && k >= 1 && k <= 8) dram_data_in = wd[8-k];
            chk({tag, "_oe"}, {31'd0, dram_data_oe}, {31'd0, rd_ok && k >= 4 && k <= 11});
            if (dram_data_oe === 1'b1 && bit_q.size() > 0)
                chk({tag, "_bit"}, {31'd0, dram_data_out}, {31'd0, bit_q.pop_front()});
            if (c == CMD_REF && k >= 2) chk({tag, "_open"}, {24'd0, bank_open}, 32'd0);
            if (cmd_ack === 1'b1) begin
                chk({tag, "_lat"}, k, lat_q.pop_front());
                chk({tag, "_err"}, {31'd0, cmd_err}, {31'd0, err_exp_q.pop_front()});
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed=no_ack expected=ack", tag);
            lat_q.delete();
            err_exp_q.delete();
        end
        chk({tag, "_bits_left"}, bit_q.size(), 32'd0);
        bit_q.delete();
        if (!e && c == CMD_ACT) open_row_m[bi] = oh2idx(r);
        if (!e && c == CMD_WR)  model_mem[key] = wd;
        if (!hold) begin
            cmd_req = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin
        rst_b = 1'b0; cmd_req = 1'b0; cmd = 2'b00; bank_sel = '0;
        row_sel = '0; col_sel = '0; dram_data_in = 1'b0;
        for (int i = 0; i < 8; i++) open_row_m[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack",  {31'd0, cmd_ack}, 32'd0);
        chk("rst_err",  {31'd0, cmd_err}, 32'd0);
        chk("rst_oe",   {31'd0, dram_data_oe}, 32'd0);
        chk("rst_dout", {31'd0, dram_data_out}, 32'd0);
        chk("rst_open", {24'd0, bank_open}, 32'd0);
        rst_b = 1'b1;
        @(posedge clk);

        run_cmd("act_b2r5", CMD_ACT, 8'h04, rowhot(5), 8'h00, 8'h00, 5, 1'b0, 1'b0);
        chk("act_b2r5_open", {24'd0, bank_open}, 32'h04);
        run_cmd("wr_a5", CMD_WR, 8'h04, '0, 8'h08, 8'hA5, 10, 1'b0, 1'b0);
        run_cmd("rd_a5", CMD_RD, 8'h04, '0, 8'h08, 8'h00, 12, 1'b0, 1'b0);

        run_cmd("rd_closed", CMD_RD, 8'h08, '0, 8'h08, 8'h00, 2, 1'b1, 1'b0);
        chk("rd_closed_open", {24'd0, bank_open}, 32'h04);
        run_cmd("act_multi", CMD_ACT, 8'h06, rowhot(5), 8'h00, 8'h00, 2, 1'b1, 1'b0);
        chk("act_multi_open", {24'd0, bank_open}, 32'h04);
        run_cmd("rd_nocol", CMD_RD, 8'h04, '0, 8'h00, 8'h00, 2, 1'b1, 1'b0);

        run_cmd("act_b2r9", CMD_ACT, 8'h04, rowhot(9), 8'h00, 8'h00, 7, 1'b0, 1'b0);
        run_cmd("wr_3c", CMD_WR, 8'h04, '0, 8'h08, 8'h3C, 10, 1'b0, 1'b0);
        run_cmd("rd_3c", CMD_RD, 8'h04, '0, 8'h08, 8'h00, 12, 1'b0, 1'b0);

        run_cmd("act_b5r1", CMD_ACT, 8'h20, rowhot(1), 8'h00, 8'h00, 5, 1'b0, 1'b0);
        chk("act_b5r1_open", {24'd0, bank_open}, 32'h24);
        run_cmd("refresh", CMD_REF, 8'h00, '0, 8'h00, 8'h00, 10, 1'b0, 1'b0);
        run_cmd("rd_after_ref", CMD_RD, 8'h04, '0, 8'h08, 8'h00, 2, 1'b1, 1'b0);

        // Reset lands in the middle of a read burst.
        run_cmd("act_pre_rst", CMD_ACT, 8'h04, rowhot(5), 8'h00, 8'h00, 5, 1'b0, 1'b0);
        @(negedge clk);
        cmd = CMD_RD; bank_sel = 8'h04; col_sel = 8'h08; cmd_req = 1'b1;
        @(posedge clk);
        repeat (7) @(negedge clk);
        chk("mid_rd_oe",   {31'd0, dram_data_oe}, 32'd1);
        chk("mid_rd_dout", {31'd0, dram_data_out}, 32'd1);
        rst_b = 1'b0;
        #1;
        chk("async_rst_oe",   {31'd0, dram_data_oe}, 32'd0);
        chk("async_rst_ack",  {31'd0, cmd_ack}, 32'd0);
        chk("async_rst_open", {24'd0, bank_open}, 32'd0);
        cmd_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);

        run_cmd("act_post_rst", CMD_ACT, 8'h04, rowhot(5), 8'h00, 8'h00, 5, 1'b0, 1'b0);
        run_cmd("rd_retained", CMD_RD, 8'h04, '0, 8'h08, 8'h00, 12, 1'b0, 1'b0);

        run_cmd("act_hold", CMD_ACT, 8'h10, rowhot(0), 8'h00, 8'h00, 5, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_no_reack", {31'd0, cmd_ack}, 32'd0);
        end
        chk("hold_open", {24'd0, bank_open}, 32'h14);
        cmd_req = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
